// File: rtl/eco_equiv_sweeper.sv
// Exhaustive equivalence sweeper for an ECO-patched combinational netlist.
// Walks every (a,b) pair through the patched and golden netlists, counts
// result mismatches (saturating), captures the first failing vector and
// reports a pass/fail verdict with a one-cycle done pulse.
module eco_equiv_sweeper #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [WIDTH-1:0] y_dut,
  input  logic [WIDTH-1:0] y_ref,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_diff
);

  localparam int IW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // First-fail capture record
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
  } fail_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  fail_t            fcap;
  logic             pass_q;
  logic             mism;
  logic             last_vec;

  // Operands come straight from the vector index; idx is held on the last
  // vector so a_out/b_out keep showing it through DONE and IDLE.
  assign a_out        = idx[IW-1:WIDTH];
  assign b_out        = idx[WIDTH-1:0];
  assign mism         = (y_dut != y_ref);
  assign last_vec     = (idx == {IW{1'b1}});
  assign busy         = (state == RUN);
  assign done         = (state == DONE);
  assign pass         = pass_q;
  assign mismatch_cnt = cnt;
  assign fail_valid   = fcap.vld;
  assign fail_a       = fcap.a;
  assign fail_b       = fcap.b;
  assign fail_diff    = fcap.diff;

  // Saturating mismatch count for the vector currently on the operands
  always_comb begin
    cnt_nxt = cnt;
    if (mism && (cnt != {CNT_W{1'b1}}))
      cnt_nxt = cnt + 1'b1;
  end

  // Next-state: IDLE waits for start, RUN ends on the last vector, DONE lasts one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_vec) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, vector index, mismatch count, first-fail capture and verdict
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      fcap   <= '0;
      pass_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            idx    <= '0;
            cnt    <= '0;
            fcap   <= '0;
            pass_q <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt_nxt;
          if (mism && !fcap.vld)
            fcap <= '{vld: 1'b1, a: a_out, b: b_out, diff: y_dut ^ y_ref};
          if (last_vec)
            pass_q <= (cnt_nxt == '0);
          else
            idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
